// File: rtl/cp0_wb_pkg.sv
// cp0_wb_pkg: shared CP0 op encodings, register numbers, field positions and write masks
package cp0_wb_pkg;
  typedef enum logic [2:0] {
    OP_NOP     = 3'b000,
    OP_MFC0    = 3'b001,
    OP_MTC0    = 3'b010,
    OP_SYSCALL = 3'b011,
    OP_ERET    = 3'b100
  } cp0_op_e;
  localparam logic [4:0]  CS_COUNT     = 5'd9;
  localparam logic [4:0]  CS_COMPARE   = 5'd11;
  localparam logic [4:0]  CS_STATUS    = 5'd12;
  localparam logic [4:0]  CS_CAUSE     = 5'd13;
  localparam logic [4:0]  CS_EPC       = 5'd14;
  localparam int          ST_IE        = 0;
  localparam int          ST_EXL       = 1;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam logic [4:0]  EXC_SYS      = 5'd8;
  localparam logic [4:0]  EXC_INT      = 5'd0;
  localparam logic [29:0] EXC_VEC      = 30'h0000_0060;
endpackage

// File: rtl/cp0_wb_timer.sv
// cp0_wb_timer: Count/Compare pair with divide-by-two tick and sticky TI, built only with CP0_TIMER_EN
`ifdef CP0_TIMER_EN
module cp0_wb_timer (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        we_count,
  input  logic        we_compare,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);
  logic [31:0] count_q, count_d, compare_q, compare_d;
  logic        tog_q, tog_d, ti_q, ti_d;
  // count ticks every other cycle; a Count write replaces that cycle's tick; a Compare write clears TI
  always_comb begin
    tog_d     = ~tog_q;
    count_d   = we_count ? wdata : count_q + {31'b0, tog_q};
    compare_d = we_compare ? wdata : compare_q;
    ti_d      = we_compare ? 1'b0 : ti_q | (count_q == compare_q);
  end
  // timer state
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      count_q   <= '0;
      compare_q <= '0;
      tog_q     <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      tog_q     <= tog_d;
      ti_q      <= ti_d;
    end
  assign count   = count_q;
  assign compare = compare_q;
  assign ti      = ti_q;
endmodule
`endif

// File: rtl/cp0_wb.sv
// cp0_wb: WB-stage CP0 (Status/Cause/EPC, optional Count/Compare under CP0_TIMER_EN) with registered redirect
module cp0_wb
  import cp0_wb_pkg::*;
#(
  parameter logic [29:0] EXC_VECTOR   = EXC_VEC,
  parameter logic [4:0]  SYSCALL_CODE = EXC_SYS
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        wr_valid,
  input  logic [2:0]  wr_cp0Op,
  input  logic [4:0]  wr_cs,
  input  logic [2:0]  wr_sel,
  input  logic [31:0] wr_busB,
  input  logic [29:0] wr_PC,
  output logic [31:0] cp0_rdata,
  output logic        exc_redirect,
  output logic [29:0] exc_target,
  output logic        int_pending
);
  logic [31:0] status_q, status_d, cause_q, cause_d, count, compare;
  logic [29:0] epc_q, epc_d, target_q, target_d;
  logic        redirect_q, redirect_d, ti, sel0, is_mtc0, is_sys, is_eret, take_int, exc;
  logic [7:0]  ip;
  assign sel0     = wr_sel == 3'd0;
  assign is_mtc0  = wr_valid & (wr_cp0Op == OP_MTC0) & sel0;
  assign is_sys   = wr_valid & (wr_cp0Op == OP_SYSCALL);
  assign is_eret  = wr_valid & (wr_cp0Op == OP_ERET);
  assign ip       = {ti, 5'b0, cause_q[9:8]};
  assign int_pending = status_q[ST_IE] & ~status_q[ST_EXL] & |(ip & status_q[15:8]);
  assign take_int = wr_valid & int_pending & ~is_sys & ~is_eret;
  assign exc      = is_sys | take_int;
`ifdef CP0_TIMER_EN
  cp0_wb_timer u_timer (
    .Clk       (Clk),
    .Rst       (Rst),
    .we_count  (is_mtc0 && wr_cs == CS_COUNT),
    .we_compare(is_mtc0 && wr_cs == CS_COMPARE),
    .wdata     (wr_busB),
    .count     (count),
    .compare   (compare),
    .ti        (ti)
  );
`else
  assign count   = '0;
  assign compare = '0;
  assign ti      = 1'b0;
`endif
  // MTC0 writes land first; exception entry/return then overrides EXL, ExcCode and EPC
  always_comb begin
    status_d         = (is_mtc0 && wr_cs == CS_STATUS) ? wr_busB & STATUS_WMASK : status_q;
    status_d[ST_EXL] = exc ? 1'b1 : is_eret ? 1'b0 : status_d[ST_EXL];
    cause_d          = (is_mtc0 && wr_cs == CS_CAUSE) ? (cause_q & ~CAUSE_WMASK) | (wr_busB & CAUSE_WMASK) : cause_q;
    cause_d[6:2]     = is_sys ? SYSCALL_CODE : take_int ? EXC_INT : cause_d[6:2];
    epc_d            = is_sys ? wr_PC : take_int ? wr_PC + 30'd1 : (is_mtc0 && wr_cs == CS_EPC) ? wr_busB[31:2] : epc_q;
    redirect_d       = exc | is_eret;
    target_d         = is_eret ? epc_q : exc ? EXC_VECTOR : target_q;
  end
  // architectural CP0 state and the redirect pulse
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      status_q   <= '0;
      cause_q    <= '0;
      epc_q      <= '0;
      redirect_q <= 1'b0;
      target_q   <= '0;
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      redirect_q <= redirect_d;
      target_q   <= target_d;
    end
  assign cp0_rdata = !sel0                 ? 32'd0 :
                     (wr_cs == CS_COUNT)   ? count :
                     (wr_cs == CS_COMPARE) ? compare :
                     (wr_cs == CS_STATUS)  ? status_q :
                     (wr_cs == CS_CAUSE)   ? cause_q | {1'b0, ti, 14'b0, ti, 15'b0} :
                     (wr_cs == CS_EPC)     ? {epc_q, 2'b00} : 32'd0;
  assign exc_redirect = redirect_q;
  assign exc_target   = target_q;
endmodule

// File: tb/tb_cp0_wb.sv
// tb_cp0_wb: directed self-checking bench for cp0_wb (timer checks run when CP0_TIMER_EN is defined)
module tb_cp0_wb;
  logic        Clk = 1'b0, Rst = 1'b1, wr_valid = 1'b0;
  logic [2:0]  wr_cp0Op = '0, wr_sel = '0;
  logic [4:0]  wr_cs = '0;
  logic [31:0] wr_busB = '0, cp0_rdata;
  logic [29:0] wr_PC = '0, exc_target;
  logic        exc_redirect, int_pending;
  int          n_cmp = 0, n_bad = 0;

  cp0_wb dut (
    .Clk(Clk), .Rst(Rst), .wr_valid(wr_valid), .wr_cp0Op(wr_cp0Op), .wr_cs(wr_cs),
    .wr_sel(wr_sel), .wr_busB(wr_busB), .wr_PC(wr_PC), .cp0_rdata(cp0_rdata),
    .exc_redirect(exc_redirect), .exc_target(exc_target), .int_pending(int_pending)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [2:0] op, input logic [4:0] cs, input logic [2:0] sel,
                      input logic [31:0] d, input logic [29:0] pc, input logic v);
    @(negedge Clk);
    wr_valid = v; wr_cp0Op = op; wr_cs = cs; wr_sel = sel; wr_busB = d; wr_PC = pc;
    @(posedge Clk);
    #1;
  endtask

  task automatic peek(input logic [4:0] cs, input logic [2:0] sel, input string tag, input logic [31:0] exp);
    wr_valid = 1'b0; wr_cp0Op = 3'b001; wr_cs = cs; wr_sel = sel;
    #1;
    chk(tag, cp0_rdata, exp);
  endtask

  task automatic mtc0(input logic [4:0] cs, input logic [31:0] d);
    step(3'b010, cs, 3'd0, d, 30'h0, 1'b1);
  endtask

  initial begin
    int          hit;
    logic        got;
    logic [31:0] epc_exp;
    hit = 0;
    got = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_redirect", {31'b0, exc_redirect}, 32'd0);
    chk("rst_target", {2'b0, exc_target}, 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    peek(5'd12, 3'd0, "rst_status", 32'd0);
    peek(5'd13, 3'd0, "rst_cause", 32'd0);
    peek(5'd14, 3'd0, "rst_epc", 32'd0);
    peek(5'd9, 3'd0, "rst_count", 32'd0);
`ifdef CP0_TIMER_EN
    mtc0(5'd11, 32'hFFFF_FFFF);
`endif
    step(3'b011, 5'd0, 3'd0, 32'd0, 30'h100, 1'b1);
    chk("sys_redirect", {31'b0, exc_redirect}, 32'd1);
    chk("sys_target", {2'b0, exc_target}, 32'h60);
    peek(5'd14, 3'd0, "sys_epc", 32'h400);
    peek(5'd13, 3'd0, "sys_cause", 32'h20);
    peek(5'd12, 3'd0, "sys_status", 32'h2);
    step(3'b000, 5'd0, 3'd0, 32'd0, 30'h60, 1'b1);
    chk("sys_pulse_end", {31'b0, exc_redirect}, 32'd0);
    step(3'b100, 5'd0, 3'd0, 32'd0, 30'h61, 1'b1);
    chk("eret_redirect", {31'b0, exc_redirect}, 32'd1);
    chk("eret_target", {2'b0, exc_target}, 32'h100);
    peek(5'd12, 3'd0, "eret_status", 32'h0);
    step(3'b000, 5'd0, 3'd0, 32'd0, 30'h100, 1'b1);
    chk("eret_pulse_end", {31'b0, exc_redirect}, 32'd0);
    mtc0(5'd12, 32'h0000_0101);
    chk("sw_idle_pending", {31'b0, int_pending}, 32'd0);
    mtc0(5'd13, 32'h0000_0100);
    chk("sw_write_noint", {31'b0, exc_redirect}, 32'd0);
    chk("sw_pending", {31'b0, int_pending}, 32'd1);
    peek(5'd13, 3'd0, "sw_cause", 32'h120);
    step(3'b000, 5'd0, 3'd0, 32'd0, 30'h200, 1'b1);
    chk("int_redirect", {31'b0, exc_redirect}, 32'd1);
    chk("int_target", {2'b0, exc_target}, 32'h60);
    chk("int_exl_masks", {31'b0, int_pending}, 32'd0);
    peek(5'd14, 3'd0, "int_epc", 32'h804);
    peek(5'd13, 3'd0, "int_cause", 32'h100);
    peek(5'd12, 3'd0, "int_status", 32'h103);
    step(3'b100, 5'd0, 3'd0, 32'd0, 30'h60, 1'b1);
    chk("eret2_target", {2'b0, exc_target}, 32'h201);
    chk("eret2_pending", {31'b0, int_pending}, 32'd1);
    step(3'b000, 5'd0, 3'd0, 32'd0, 30'h201, 1'b0);
    chk("bubble_noint", {31'b0, exc_redirect}, 32'd0);
    step(3'b011, 5'd0, 3'd0, 32'd0, 30'h300, 1'b1);
    chk("sys_over_int_redirect", {31'b0, exc_redirect}, 32'd1);
    peek(5'd13, 3'd0, "sys_over_int_cause", 32'h120);
    peek(5'd14, 3'd0, "sys_over_int_epc", 32'hC00);
    step(3'b000, 5'd0, 3'd0, 32'd0, 30'h301, 1'b1);
    chk("exl_blocks_int", {31'b0, exc_redirect}, 32'd0);
    step(3'b100, 5'd0, 3'd0, 32'd0, 30'h60, 1'b1);
    chk("eret3_target", {2'b0, exc_target}, 32'h300);
    step(3'b000, 5'd0, 3'd0, 32'd0, 30'h400, 1'b1);
    chk("deferred_int_redirect", {31'b0, exc_redirect}, 32'd1);
    peek(5'd14, 3'd0, "deferred_int_epc", 32'h1004);
    step(3'b100, 5'd0, 3'd0, 32'd0, 30'h60, 1'b1);
    chk("eret4_target", {2'b0, exc_target}, 32'h401);
    step(3'b010, 5'd13, 3'd0, 32'd0, 30'h500, 1'b1);
    chk("mtc0_int_redirect", {31'b0, exc_redirect}, 32'd1);
    peek(5'd13, 3'd0, "mtc0_int_cause", 32'h0);
    peek(5'd14, 3'd0, "mtc0_int_epc", 32'h1404);
    mtc0(5'd12, 32'd0);
    peek(5'd12, 3'd0, "status_clear", 32'd0);
    mtc0(5'd15, 32'hDEAD_BEEF);
    peek(5'd15, 3'd0, "cs15_read", 32'd0);
    step(3'b010, 5'd14, 3'd1, 32'h1234_5678, 30'h0, 1'b1);
    peek(5'd14, 3'd1, "sel1_read", 32'd0);
    peek(5'd14, 3'd0, "sel1_no_write", 32'h1404);
    mtc0(5'd12, 32'hFFFF_FFFF);
    peek(5'd12, 3'd0, "status_mask", 32'h0000_FF03);
    chk("status_mask_pending", {31'b0, int_pending}, 32'd0);
    mtc0(5'd12, 32'd0);
    mtc0(5'd14, 32'h1234_5677);
    peek(5'd14, 3'd0, "epc_write", 32'h1234_5674);
`ifdef CP0_TIMER_EN
    mtc0(5'd11, 32'd4);
    mtc0(5'd9, 32'd0);
    mtc0(5'd12, 32'h0000_8001);
    for (int i = 0; i < 40 && !got; i++) begin
      step(3'b000, 5'd0, 3'd0, 32'd0, 30'(30'h500 + i), 1'b1);
      if (exc_redirect) begin
        got = 1'b1;
        hit = i;
      end
    end
    chk("ti_int_seen", {31'b0, got}, 32'd1);
    chk("ti_latency_ok", {31'b0, (hit >= 4 && hit <= 14)}, 32'd1);
    chk("ti_target", {2'b0, exc_target}, 32'h60);
    epc_exp = (32'h500 + 32'(hit) + 32'd1) * 32'd4;
    peek(5'd14, 3'd0, "ti_epc", epc_exp);
    peek(5'd13, 3'd0, "ti_cause", 32'h4000_8000);
    mtc0(5'd11, 32'd100);
    peek(5'd13, 3'd0, "ti_cleared", 32'd0);
    mtc0(5'd9, 32'h10);
    peek(5'd9, 3'd0, "count_write", 32'h10);
    mtc0(5'd12, 32'd0);
`else
    mtc0(5'd9, 32'h55);
    peek(5'd9, 3'd0, "no_timer_count", 32'd0);
    mtc0(5'd11, 32'h55);
    peek(5'd11, 3'd0, "no_timer_compare", 32'd0);
    mtc0(5'd13, 32'h4000_8000);
    peek(5'd13, 3'd0, "no_timer_cause", 32'd0);
    chk("no_timer_pending", {31'b0, int_pending}, 32'd0);
`endif
    step(3'b011, 5'd0, 3'd0, 32'd0, 30'h700, 1'b1);
    chk("pre_reset_redirect", {31'b0, exc_redirect}, 32'd1);
    Rst = 1'b1;
    #1;
    chk("mid_reset_redirect", {31'b0, exc_redirect}, 32'd0);
    chk("mid_reset_target", {2'b0, exc_target}, 32'd0);
    peek(5'd14, 3'd0, "mid_reset_epc", 32'd0);
    peek(5'd12, 3'd0, "mid_reset_status", 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
